// File: rtl/latch_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : latch_seq_pkg
// Purpose  : Shared types and constants for the gated-latch write sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package latch_seq_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      PULSE = 3'd2,
      HOLD  = 3'd3,
      CHECK = 3'd4
   } state_t;

   localparam int SYNC_STAGES = 2;
   localparam int CHECK_CYC   = 2;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage
`default_nettype wire

// File: rtl/latch_write_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : latch_write_sequencer_if
// Purpose  : Request handshake plus latch-bank bus for the write sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface latch_write_sequencer_if #(
   parameter int N_LATCH = 8,
   parameter int AW      = $clog2(N_LATCH)
);
   logic               req_valid;
   logic               req_ready;
   logic [AW-1:0]      req_addr;
   logic               req_data;
   logic               lat_d;
   logic [N_LATCH-1:0] lat_en;
   logic [N_LATCH-1:0] lat_q;
   logic               done;
   logic               err;
   logic [AW-1:0]      err_addr;

   // master = requester together with the latch bank driving Q back
   modport master (
      output req_valid, req_addr, req_data, lat_q,
      input  req_ready, lat_d, lat_en, done, err, err_addr
   );

   modport slave (
      input  req_valid, req_addr, req_data, lat_q,
      output req_ready, lat_d, lat_en, done, err, err_addr
   );
endinterface
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Purpose  : N-bit double-flop synchronizer, cleared by synchronous reset.
// Revision : 1.0 - initial release
// ============================================================================
module sync_2ff #(
   parameter int WIDTH = 8
) (
   input  wire logic             clk,
   input  wire logic             rst,
   input  wire logic [WIDTH-1:0] i_d,
   output logic      [WIDTH-1:0] o_q
);
   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_meta <= '0;
         r_sync <= '0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;
endmodule
`default_nettype wire

// File: rtl/latch_write_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : latch_write_sequencer
// Purpose  : Drives setup/pulse/hold write cycles into a NAND gated-latch
//            bank and verifies each write through a synchronized readback.
// Revision : 1.0 - initial release
// ============================================================================
module latch_write_sequencer
   import latch_seq_pkg::*;
#(
   parameter int N_LATCH   = 8,
   parameter int AW        = $clog2(N_LATCH),
   parameter int SETUP_CYC = 2,
   parameter int PULSE_CYC = 4,
   parameter int HOLD_CYC  = 2
) (
   input wire logic               clk,
   input wire logic               rst,
   latch_write_sequencer_if.slave bus
);
   localparam int c_MAX_CYC = max3(SETUP_CYC, PULSE_CYC, HOLD_CYC);
   localparam int c_CNT_W   = $clog2(c_MAX_CYC + 1);

   localparam logic [c_CNT_W-1:0] c_SETUP_LD = c_CNT_W'(SETUP_CYC - 1);
   localparam logic [c_CNT_W-1:0] c_PULSE_LD = c_CNT_W'(PULSE_CYC - 1);
   localparam logic [c_CNT_W-1:0] c_HOLD_LD  = c_CNT_W'(HOLD_CYC - 1);
   localparam logic [c_CNT_W-1:0] c_CHECK_LD = c_CNT_W'(CHECK_CYC - 1);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
   localparam logic [AW:0]        c_N_LATCH  = (AW + 1)'(N_LATCH);

   state_t               r_state;
   state_t               w_state_n;
   logic [c_CNT_W-1:0]   r_cnt;
   logic [c_CNT_W-1:0]   w_cnt_n;
   logic [AW-1:0]        r_addr;
   logic                 r_data;
   logic                 r_lat_d;
   logic [N_LATCH-1:0]   r_lat_en;
   logic                 r_done;
   logic                 r_err;
   logic [AW-1:0]        r_err_addr;

   logic                 w_accept;
   logic                 w_addr_bad;
   logic                 w_done_n;
   logic                 w_err_n;
   logic [AW-1:0]        w_err_addr_n;
   logic [N_LATCH-1:0]   w_dec;
   logic [N_LATCH-1:0]   w_sync_q;
   logic                 w_q_sel;

   sync_2ff #(
      .WIDTH (N_LATCH)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .i_d (bus.lat_q),
      .o_q (w_sync_q)
   );

   // Indices past the bank decode to all-zero, so a bad address never strobes.
   for (genvar gi = 0; gi < N_LATCH; gi++) begin : g_dec
      assign w_dec[gi] = (r_addr == AW'(gi));
   end

   assign w_q_sel    = |(w_sync_q & w_dec);
   assign w_addr_bad = ({1'b0, bus.req_addr} >= c_N_LATCH);

   always_comb begin
      w_state_n    = r_state;
      w_cnt_n      = r_cnt;
      w_accept     = 1'b0;
      w_done_n     = 1'b0;
      w_err_n      = 1'b0;
      w_err_addr_n = r_addr;
      case (r_state)
         IDLE: begin
            if (bus.req_valid) begin
               w_accept = 1'b1;
               if (w_addr_bad) begin
                  w_done_n     = 1'b1;
                  w_err_n      = 1'b1;
                  w_err_addr_n = bus.req_addr;
               end else begin
                  w_state_n = SETUP;
                  w_cnt_n   = c_SETUP_LD;
               end
            end
         end
         SETUP: begin
            if (r_cnt == '0) begin
               w_state_n = PULSE;
               w_cnt_n   = c_PULSE_LD;
            end else begin
               w_cnt_n = r_cnt - c_CNT_ONE;
            end
         end
         PULSE: begin
            if (r_cnt == '0) begin
               w_state_n = HOLD;
               w_cnt_n   = c_HOLD_LD;
            end else begin
               w_cnt_n = r_cnt - c_CNT_ONE;
            end
         end
         HOLD: begin
            if (r_cnt == '0) begin
               w_state_n = CHECK;
               w_cnt_n   = c_CHECK_LD;
            end else begin
               w_cnt_n = r_cnt - c_CNT_ONE;
            end
         end
         CHECK: begin
            // The counter also spans the synchronizer latency before compare.
            if (r_cnt == '0) begin
               w_state_n = IDLE;
               w_done_n  = 1'b1;
               w_err_n   = (w_q_sel != r_data);
            end else begin
               w_cnt_n = r_cnt - c_CNT_ONE;
            end
         end
         default: begin
            w_state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_addr     <= '0;
         r_data     <= 1'b0;
         r_lat_d    <= 1'b0;
         r_lat_en   <= '0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_err_addr <= '0;
      end else begin
         r_state  <= w_state_n;
         r_cnt    <= w_cnt_n;
         r_done   <= w_done_n;
         r_err    <= w_err_n;
         // Enable is a flop fed from the next state, so it rises and falls on state edges only.
         r_lat_en <= (w_state_n == PULSE) ? w_dec : '0;
         if (w_accept) begin
            r_addr  <= bus.req_addr;
            r_data  <= bus.req_data;
            r_lat_d <= bus.req_data;
         end
         if (w_err_n) begin
            r_err_addr <= w_err_addr_n;
         end
      end
   end

   assign bus.req_ready = (r_state == IDLE);
   assign bus.lat_d     = r_lat_d;
   assign bus.lat_en    = r_lat_en;
   assign bus.done      = r_done;
   assign bus.err       = r_err;
   assign bus.err_addr  = r_err_addr;
endmodule
`default_nettype wire

// File: tb/tb_latch_write_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_latch_write_sequencer
// Purpose  : Directed bench for latch_write_sequencer against a NAND latch model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_latch_write_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic stuck5 = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;
   logic [7:0] q_vec;

   always #5 clk = ~clk;

   latch_write_sequencer_if #(.N_LATCH(8)) bus8 ();
   latch_write_sequencer_if #(.N_LATCH(6)) bus6 ();

   latch_write_sequencer #(.N_LATCH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
   latch_write_sequencer #(.N_LATCH(6)) dut6 (.clk(clk), .rst(rst), .bus(bus6));

   // Cross-coupled NAND gated D latch per bit, each gate with 1 ns delay.
   for (genvar gi = 0; gi < 8; gi++) begin : g_latch
      logic sn = 1'b1;
      logic rn = 1'b1;
      logic q  = 1'b0;
      logic qn = 1'b1;
      always @(bus8.lat_d or bus8.lat_en[gi]) begin
         sn <= #1 ~(bus8.lat_d & bus8.lat_en[gi]);
         rn <= #1 ~(~bus8.lat_d & bus8.lat_en[gi]);
      end
      always @(sn or qn) q  <= #1 ~(sn & qn);
      always @(rn or q)  qn <= #1 ~(rn & q);
      assign q_vec[gi] = q;
   end

   assign bus8.lat_q = stuck5 ? (q_vec & 8'hDF) : q_vec;
   assign bus6.lat_q = '0;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      n_chk++; if (bus8.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", bus8.req_ready); end
      n_chk++; if (bus8.lat_en !== 8'h00) begin n_fail++; $display("FAIL reset_en got=%h exp=00", bus8.lat_en); end
      n_chk++; if (bus8.lat_d !== 1'b0) begin n_fail++; $display("FAIL reset_d got=%b exp=0", bus8.lat_d); end
      n_chk++; if ({bus8.done, bus8.err} !== 2'b00) begin n_fail++; $display("FAIL reset_done_err got=%b exp=00", {bus8.done, bus8.err}); end
      n_chk++; if (bus8.err_addr !== 3'd0) begin n_fail++; $display("FAIL reset_err_addr got=%0d exp=0", bus8.err_addr); end
      n_chk++; if (bus6.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready6 got=%b exp=1", bus6.req_ready); end
   endtask

   task automatic test_write;
      logic [7:0] exp_en;
      bus8.req_valid = 1'b1; bus8.req_addr = 3'd3; bus8.req_data = 1'b1;
      tick();
      bus8.req_valid = 1'b0; bus8.req_data = 1'b0;
      for (int c = 1; c <= 11; c++) begin
         exp_en = (c >= 3 && c <= 6) ? 8'h08 : 8'h00;
         n_chk++; if (bus8.lat_en !== exp_en) begin n_fail++; $display("FAIL write_en c=%0d got=%h exp=%h", c, bus8.lat_en, exp_en); end
         n_chk++; if (bus8.done !== (c == 11)) begin n_fail++; $display("FAIL write_done c=%0d got=%b exp=%b", c, bus8.done, (c == 11)); end
         n_chk++; if (bus8.req_ready !== (c == 11)) begin n_fail++; $display("FAIL write_ready c=%0d got=%b exp=%b", c, bus8.req_ready, (c == 11)); end
         if (c < 11) tick();
      end
      n_chk++; if (bus8.err !== 1'b0) begin n_fail++; $display("FAIL write_err got=%b exp=0", bus8.err); end
      n_chk++; if (bus8.lat_d !== 1'b1) begin n_fail++; $display("FAIL write_lat_d got=%b exp=1", bus8.lat_d); end
      n_chk++; if (q_vec[3] !== 1'b1) begin n_fail++; $display("FAIL write_q3 got=%b exp=1", q_vec[3]); end
   endtask

   task automatic test_back_to_back;
      logic [7:0] exp_en;
      bus8.req_valid = 1'b1; bus8.req_addr = 3'd3; bus8.req_data = 1'b0;
      tick();
      bus8.req_addr = 3'd2; bus8.req_data = 1'b1;
      for (int c = 1; c <= 22; c++) begin
         if (c <= 11) exp_en = (c >= 3 && c <= 6) ? 8'h08 : 8'h00;
         else         exp_en = (c >= 14 && c <= 17) ? 8'h04 : 8'h00;
         n_chk++; if (bus8.lat_en !== exp_en) begin n_fail++; $display("FAIL b2b_en c=%0d got=%h exp=%h", c, bus8.lat_en, exp_en); end
         n_chk++; if ($countones(bus8.lat_en) > 1) begin n_fail++; $display("FAIL b2b_onehot c=%0d got=%h exp=onehot", c, bus8.lat_en); end
         n_chk++; if (bus8.done !== (c == 11 || c == 22)) begin n_fail++; $display("FAIL b2b_done c=%0d got=%b exp=%b", c, bus8.done, (c == 11 || c == 22)); end
         n_chk++; if (bus8.req_ready !== (c == 11 || c == 22)) begin n_fail++; $display("FAIL b2b_ready c=%0d got=%b exp=%b", c, bus8.req_ready, (c == 11 || c == 22)); end
         if (c == 11) begin
            n_chk++; if (q_vec[3] !== 1'b0) begin n_fail++; $display("FAIL b2b_q3 got=%b exp=0", q_vec[3]); end
            n_chk++; if (bus8.err !== 1'b0) begin n_fail++; $display("FAIL b2b_err1 got=%b exp=0", bus8.err); end
         end
         if (c == 12) begin
            bus8.req_valid = 1'b0;
            n_chk++; if (bus8.lat_d !== 1'b1) begin n_fail++; $display("FAIL b2b_lat_d got=%b exp=1", bus8.lat_d); end
         end
         if (c < 22) tick();
      end
      n_chk++; if (bus8.err !== 1'b0) begin n_fail++; $display("FAIL b2b_err2 got=%b exp=0", bus8.err); end
      n_chk++; if (q_vec[3:2] !== 2'b01) begin n_fail++; $display("FAIL b2b_q32 got=%b exp=01", q_vec[3:2]); end
   endtask

   task automatic test_stuck;
      stuck5 = 1'b1;
      bus8.req_valid = 1'b1; bus8.req_addr = 3'd5; bus8.req_data = 1'b1;
      tick();
      bus8.req_valid = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         n_chk++; if (bus8.done !== (c == 11)) begin n_fail++; $display("FAIL stuck_done c=%0d got=%b exp=%b", c, bus8.done, (c == 11)); end
         n_chk++; if (bus8.err !== (c == 11)) begin n_fail++; $display("FAIL stuck_err c=%0d got=%b exp=%b", c, bus8.err, (c == 11)); end
         if (c >= 11) begin
            n_chk++; if (bus8.err_addr !== 3'd5) begin n_fail++; $display("FAIL stuck_err_addr c=%0d got=%0d exp=5", c, bus8.err_addr); end
         end
         if (c < 12) tick();
      end
      stuck5 = 1'b0;
   endtask

   task automatic test_bad_addr;
      bus6.req_valid = 1'b1; bus6.req_addr = 3'd7; bus6.req_data = 1'b1;
      tick();
      bus6.req_valid = 1'b0;
      n_chk++; if ({bus6.done, bus6.err} !== 2'b11) begin n_fail++; $display("FAIL bad_done_err got=%b exp=11", {bus6.done, bus6.err}); end
      n_chk++; if (bus6.err_addr !== 3'd7) begin n_fail++; $display("FAIL bad_err_addr got=%0d exp=7", bus6.err_addr); end
      n_chk++; if (bus6.req_ready !== 1'b1) begin n_fail++; $display("FAIL bad_ready got=%b exp=1", bus6.req_ready); end
      for (int c = 1; c <= 4; c++) begin
         n_chk++; if (bus6.lat_en !== 6'h00) begin n_fail++; $display("FAIL bad_en c=%0d got=%h exp=00", c, bus6.lat_en); end
         tick();
      end
      n_chk++; if ({bus6.done, bus6.err} !== 2'b00) begin n_fail++; $display("FAIL bad_pulse_len got=%b exp=00", {bus6.done, bus6.err}); end
      n_chk++; if (bus6.err_addr !== 3'd7) begin n_fail++; $display("FAIL bad_err_addr_hold got=%0d exp=7", bus6.err_addr); end
   endtask

   task automatic test_reset_mid;
      bus8.req_valid = 1'b1; bus8.req_addr = 3'd1; bus8.req_data = 1'b1;
      tick();
      bus8.req_valid = 1'b0;
      repeat (3) tick();
      n_chk++; if (bus8.lat_en !== 8'h02) begin n_fail++; $display("FAIL mid_pulse_en got=%h exp=02", bus8.lat_en); end
      rst = 1'b1;
      tick();
      n_chk++; if (bus8.lat_en !== 8'h00) begin n_fail++; $display("FAIL mid_en_drop got=%h exp=00", bus8.lat_en); end
      n_chk++; if (bus8.err_addr !== 3'd0) begin n_fail++; $display("FAIL mid_err_addr got=%0d exp=0", bus8.err_addr); end
      tick();
      rst = 1'b0;
      for (int c = 0; c < 12; c++) begin
         tick();
         n_chk++; if ({bus8.done, bus8.lat_en} !== 9'h000) begin n_fail++; $display("FAIL mid_quiet c=%0d got=%h exp=000", c, {bus8.done, bus8.lat_en}); end
         n_chk++; if (bus8.req_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready c=%0d got=%b exp=1", c, bus8.req_ready); end
      end
   endtask

   initial begin
      bus8.req_valid = 1'b0; bus8.req_addr = '0; bus8.req_data = 1'b0;
      bus6.req_valid = 1'b0; bus6.req_addr = '0; bus6.req_data = 1'b0;
      test_reset();
      test_write();
      test_back_to_back();
      tick();
      test_stuck();
      test_bad_addr();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/latch_write_sequencer.md
# latch_write_sequencer

Sequences write cycles into a bank of NAND-built gated D latches, the asynchronous storage elements used elsewhere in this Basys3 design. One write request at a time is accepted. For each request the block:
- drives the shared latch D line;
- waits a setup interval;
- raises exactly one latch enable for a fixed pulse width;
- holds D stable after the enable falls;
- reads the latch Q back through a synchronizer and reports done or a mismatch.

It sits between synchronous control logic (switch/button decoders, test FSMs) and the latch array.

## Interface
Parameters:
- N_LATCH, 8, number of latches in the bank (2..32)
- AW, $clog2(N_LATCH), request address width
- SETUP_CYC, 2, cycles D is stable before the enable rises (≥1)
- PULSE_CYC, 4, cycles the enable is high (≥1)
- HOLD_CYC, 2, cycles D is held after the enable falls (≥1)

Ports:
- clk  in  1  system clock; all logic is on the rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  write request present
- req_ready  out  1  block can accept a request; equals (state==IDLE)
- req_addr  in  AW  latch index
- req_data  in  1  value to store
- lat_d  out  1  shared D line to all latches
- lat_en  out  N_LATCH  one-hot (or zero) enable vector
- lat_q  in  N_LATCH  latch Q outputs; asynchronous, synchronized internally
- done  out  1  one-cycle pulse when a request completes
- err  out  1  one-cycle pulse, coincident with done, on readback mismatch or bad address
- err_addr  out  AW  address of the last errored request; holds its value until the next error

## Operation
- FSM states: IDLE, SETUP, PULSE, HOLD, CHECK.
- A request is accepted when req_valid and req_ready are both high at a clk edge. On that edge the block registers addr and data, and lat_d <= req_data.
- Normal sequence: IDLE → SETUP (SETUP_CYC cycles) → PULSE (PULSE_CYC cycles) → HOLD (HOLD_CYC cycles) → CHECK (2 cycles) → IDLE.
- lat_en:
  - During PULSE, lat_en[addr] = 1 and all other bits are 0.
  - In every other state, lat_en is all zeros.
  - lat_en is registered; it must never glitch.
- lat_d keeps its value from accept until the next accept, including through IDLE.
- CHECK:
  - lat_q passes through a 2-flop synchronizer.
  - The 2-cycle CHECK covers the synchronizer latency.
  - On the last CHECK cycle the block compares sync_q[addr] against the stored data.
- Completion:
  - The cycle after CHECK is IDLE, with done=1 and req_ready=1.
  - err=1 in that cycle if the comparison mismatched; err_addr is then updated.
- Out-of-range address (addr ≥ N_LATCH, possible only when N_LATCH is not a power of 2):
  - The request is accepted, no enable is raised, and the state stays IDLE.
  - done=1 and err=1 are asserted in the next cycle, and err_addr is updated.
- A single down-counter is shared by SETUP, PULSE and HOLD. Its width is $clog2(max(SETUP_CYC,PULSE_CYC,HOLD_CYC)+1). It is loaded on each state entry.
- Reset:
  - All outputs go to 0 and the state goes to IDLE.
  - Synchronizer flops go to 0.
  - Reset mid-operation drops lat_en on that edge and produces no done pulse. The partially written latch is left undefined; the bench must not check it.

## Timing
- Accept at edge k gives:
  - SETUP in cycles k+1..k+SETUP_CYC;
  - lat_en high for exactly PULSE_CYC cycles starting at cycle k+SETUP_CYC+1;
  - done at cycle k+SETUP_CYC+PULSE_CYC+HOLD_CYC+3. With defaults this is k+11.
- Throughput: one write per SETUP_CYC+PULSE_CYC+HOLD_CYC+3 cycles. A new request can be accepted on the done cycle.
- req_valid and the request fields are sampled only at the accept edge; later changes are ignored.
- Reset values: req_ready=1 (from the first cycle after reset), lat_d=0, lat_en=0, done=0, err=0, err_addr=0.

## Structure
- Package latch_seq_pkg holds:
  - the state encoding constants (IDLE..CHECK);
  - SYNC_STAGES=2;
  - CHECK_CYC=2.
- Sub-module sync_2ff holds the parameterized N-bit double-flop synchronizer for lat_q, with reset to 0.
- The FSM, the counter and the output registers are in the top module.

## Test plan
The bench drives lat_q from a behavioral gated-latch model with #1 gate delays.
- Reset: hold rst for 3 cycles → req_ready=1; lat_en, lat_d, done and err all 0.
- Write addr=3, data=1 at edge 0 → lat_en=8'h08 for cycles 3–6 only; done=1 and err=0 at cycle 11; model Q[3]=1.
- Write addr=3, data=0 with req_valid held high and a second request queued → second accept occurs on the done cycle; Q[3]=0 afterwards; lat_en is never multi-hot.
- Stuck-at fault: force the model's Q[5]=0 and write addr=5, data=1 → done=1, err=1 and err_addr=5 at cycle 11.
- With N_LATCH=6, write addr=7 → no lat_en activity; done=1 and err=1 at cycle 1; err_addr=7.
- Assert rst during PULSE (cycle 4) → lat_en=0 on the next edge; no done pulse; req_ready=1 after reset is released.
